// File: rtl/cache_pmem_arbiter.sv
// Arbitrates the shared physical-memory line port between the I-cache and D-cache.
// One transaction at a time, held until pmem_resp; simultaneous requests alternate.
module cache_pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Every completion returns through IDLE so a request level still high in the
    // response cycle is treated as a fresh request rather than re-granted early.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req)
                    state_d = last_d_q ? I_BUSY : D_BUSY;
                else if (i_req)
                    state_d = I_BUSY;
                else if (d_req)
                    state_d = D_BUSY;
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b0;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    state_d  = IDLE;
                    last_d_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port muxing decodes the registered grant so reset clears pmem requests immediately.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_q)
            I_BUSY: begin
                pmem_read    = 1'b1;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            D_BUSY: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    a_no_d_read_write: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_pmem_read && d_pmem_write))
        else $fatal(1, "cache_pmem_arbiter: d_pmem_read and d_pmem_write both high");

    a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) || (state_q == I_BUSY) || (state_q == D_BUSY))
        else $fatal(1, "cache_pmem_arbiter: illegal state encoding");

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// Bench for cache_pmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant history queue + current owner).
module tb_cache_pmem_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int checks_total  = 0;
    int checks_passed = 0;

    cache_pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_pmem_read  = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        pmem_resp    = 1'b0;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        idle_inputs();
        i_pmem_read = 1'b1;
        d_pmem_write = 1'b1;
        pmem_resp = 1'b1;
        pmem_rdata = rand_line();
        #3;
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || pmem_address !== '0 || pmem_wdata !== '0)
            $display("FAIL reset_outputs: flags=%b addr=%h required flags=0000 addr=0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address);
        else checks_passed++;
        checks_total++;
        if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata)
            $display("FAIL reset_rdata_passthru: i=%h d=%h required=%h", i_pmem_rdata, d_pmem_rdata, pmem_rdata);
        else checks_passed++;
        cyc();
        cyc();
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000)
            $display("FAIL reset_held: flags=%b required=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        else checks_passed++;
        idle_inputs();
        rst_n = 1'b1;
        cyc();
        $display("txn reset released");
    endtask

    task automatic test_i_only();
        i_pmem_address = 32'h0000_1000;
        i_pmem_read = 1'b1;
        #1;
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000)
            $display("FAIL i_only_c0: flags=%b required=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        else checks_passed++;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            pmem_resp = (c == 4);
            #1;
            checks_total++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== {2'b10, c == 4, 1'b0} || pmem_address !== 32'h0000_1000)
                $display("FAIL i_only_c%0d: flags=%b addr=%h required flags=%b addr=00001000", c, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address, {2'b10, c == 4, 1'b0});
            else checks_passed++;
        end
        cyc();
        idle_inputs();
        #1;
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || pmem_address !== '0)
            $display("FAIL i_only_c5_idle: flags=%b addr=%h required flags=0000 addr=0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address);
        else checks_passed++;
        $display("txn I read addr=%h", 32'h0000_1000);
    endtask

    task automatic test_d_writeback();
        d_pmem_address = 32'h0000_2040;
        d_pmem_wdata = {32{8'hA5}};
        d_pmem_write = 1'b1;
        #1;
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000)
            $display("FAIL d_wb_c0: flags=%b required=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        else checks_passed++;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            pmem_resp = (c == 3);
            #1;
            checks_total++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== {3'b010, c == 3} || pmem_address !== 32'h0000_2040 || pmem_wdata !== {32{8'hA5}})
                $display("FAIL d_wb_c%0d: flags=%b addr=%h wdata=%h required flags=%b", c, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address, pmem_wdata, {3'b010, c == 3});
            else checks_passed++;
        end
        cyc();
        idle_inputs();
        #1;
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || pmem_wdata !== '0)
            $display("FAIL d_wb_idle: flags=%b wdata=%h required flags=0000 wdata=0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_wdata);
        else checks_passed++;
        $display("txn D write addr=%h", 32'h0000_2040);
    endtask

    task automatic test_tie();
        logic [ADDR_W-1:0] a_i, a_d;
        logic [3:0] exp_f [1:8];
        logic [ADDR_W-1:0] exp_a [1:8];
        a_i = 32'h0000_3000;
        a_d = 32'h0000_4000;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        i_pmem_address = a_i;
        d_pmem_address = a_d;
        i_pmem_read = 1'b1;
        d_pmem_read = 1'b1;
        exp_f = '{4'b1000, 4'b1010, 4'b0000, 4'b1001, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
        exp_a = '{a_i, a_i, 32'h0, a_d, 32'h0, a_i, 32'h0, 32'h0};
        for (int c = 1; c <= 8; c++) begin
            cyc();
            pmem_resp = (c == 2 || c == 4 || c == 6);
            if (c == 3) i_pmem_read = 1'b0;
            if (c == 5) i_pmem_read = 1'b1;
            if (c == 7) begin
                i_pmem_read = 1'b0;
                d_pmem_read = 1'b0;
            end
            #1;
            checks_total++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== exp_f[c] || pmem_address !== exp_a[c])
                $display("FAIL tie_c%0d: flags=%b addr=%h required flags=%b addr=%h", c, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address, exp_f[c], exp_a[c]);
            else checks_passed++;
        end
        idle_inputs();
        $display("txn tie sequence I, D, I");
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_f [1:5];
        i_pmem_address = 32'h0000_5000;
        i_pmem_read = 1'b1;
        exp_f = '{4'b1010, 4'b0000, 4'b1000, 4'b1010, 4'b0000};
        for (int c = 1; c <= 5; c++) begin
            cyc();
            pmem_resp = (c == 1 || c == 4);
            if (c == 5) i_pmem_read = 1'b0;
            #1;
            checks_total++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== exp_f[c])
                $display("FAIL b2b_c%0d: flags=%b required=%b", c, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, exp_f[c]);
            else checks_passed++;
        end
        idle_inputs();
        $display("txn I back-to-back x2 addr=%h", 32'h0000_5000);
    endtask

    task automatic test_reset_mid_op();
        d_pmem_address = 32'h0000_6000;
        d_pmem_wdata = rand_line();
        d_pmem_write = 1'b1;
        cyc();
        checks_total++;
        if (pmem_write !== 1'b1)
            $display("FAIL rst_mid_busy: pmem_write=%b required=1", pmem_write);
        else checks_passed++;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if ({pmem_read, pmem_write} !== 2'b00 || pmem_wdata !== '0)
            $display("FAIL rst_mid_async: rd/wr=%b required=00", {pmem_read, pmem_write});
        else checks_passed++;
        d_pmem_write = 1'b0;
        cyc();
        rst_n = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checks_total++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00)
            $display("FAIL rst_mid_stray_resp: resps=%b required=00", {i_pmem_resp, d_pmem_resp});
        else checks_passed++;
        cyc();
        checks_total++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000)
            $display("FAIL rst_mid_still_idle: flags=%b required=0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
        else checks_passed++;
        idle_inputs();
        $display("txn D write aborted by reset");
    endtask

    // Model: owner of the port (0 none, 1 I, 2 D) and the history of completed grants.
    // A tie goes to whichever side did not complete most recently (I if nobody has).
    task automatic test_random();
        int served[$];
        int owner = 0;
        bit i_act = 0, d_act = 0, d_w = 0;
        bit pm_busy = 0;
        int pm_cnt = 0;
        logic [3:0] e_f;
        logic [ADDR_W-1:0] e_a;
        logic [LINE_W-1:0] e_wd;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 800; n++) begin
            cyc();
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act = 1;
                i_pmem_address = $urandom & 32'hFFFF_FFE0;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1;
                d_w = 1'($urandom_range(0, 1));
                d_pmem_address = $urandom & 32'hFFFF_FFE0;
                d_pmem_wdata = rand_line();
            end
            i_pmem_read = i_act;
            d_pmem_read = d_act && !d_w;
            d_pmem_write = d_act && d_w;
            pmem_rdata = rand_line();
            pmem_resp = pm_busy ? (pm_cnt == 0) : ($urandom_range(0, 7) == 0);
            #1;
            e_f = 4'b0000;
            e_a = '0;
            e_wd = '0;
            if (owner == 1) begin
                e_f = {2'b10, pmem_resp, 1'b0};
                e_a = i_pmem_address;
            end else if (owner == 2) begin
                e_f = {d_pmem_read, d_pmem_write, 1'b0, pmem_resp};
                e_a = d_pmem_address;
                e_wd = d_pmem_wdata;
            end
            checks_total++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== e_f || pmem_address !== e_a)
                $display("FAIL rand_ctrl cyc%0d: flags=%b addr=%h required flags=%b addr=%h", n, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address, e_f, e_a);
            else checks_passed++;
            checks_total++;
            if (pmem_wdata !== e_wd || i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata)
                $display("FAIL rand_data cyc%0d: wdata=%h required=%h", n, pmem_wdata, e_wd);
            else checks_passed++;
            if (i_pmem_resp) $display("txn I read addr=%h", i_pmem_address);
            if (d_pmem_resp) $display("txn D %s addr=%h", d_w ? "write" : "read", d_pmem_address);
            if (owner != 0) begin
                if (pmem_resp) begin
                    served.push_back(owner);
                    owner = 0;
                end
            end else begin
                if (i_pmem_read && (d_pmem_read || d_pmem_write))
                    owner = (served.size() == 0 || served[$] == 2) ? 1 : 2;
                else if (i_pmem_read)
                    owner = 1;
                else if (d_pmem_read || d_pmem_write)
                    owner = 2;
            end
            if (i_pmem_resp) i_act = ($urandom_range(0, 3) == 0);
            if (d_pmem_resp) d_act = ($urandom_range(0, 3) == 0);
            if (pmem_resp) pm_busy = 0;
            else if (pm_busy) pm_cnt--;
            else if (pmem_read || pmem_write) begin
                pm_busy = 1;
                pm_cnt = $urandom_range(0, 3);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_i_only();
        test_d_writeback();
        test_tie();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        cyc();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
